prga: RTL
=========

# prga

Pseudo-random generation stage of the ARC4 datapath. Once `ksa` has permuted the shared 256×8 S memory, `prga` reads S back, continues the permutation and generates the keystream. It XORs the keystream with a length-prefixed ciphertext memory and writes the resulting length-prefixed plaintext memory. It uses the same `en`/`rdy` request handshake as `ksa` and shares S-memory port signalling with it.

## Interface
- No parameters; all widths are fixed at 8-bit data and 8-bit addresses.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; sampled only while `rdy`=1.
- `rdy`  out  1  1 = idle and able to accept `en`.
- `s_addr`  out  8  S memory address.
- `s_rddata`  in  8  S memory read data.
- `s_wrdata`  out  8  S memory write data.
- `s_wren`  out  1  S memory write enable.
- `ct_addr`  out  8  ciphertext memory address (read-only port).
- `ct_rddata`  in  8  ciphertext memory read data.
- `pt_addr`  out  8  plaintext memory address.
- `pt_wrdata`  out  8  plaintext memory write data.
- `pt_wren`  out  1  plaintext memory write enable.
- `pt_valid`  out  1  all-printable flag; present only with `PRGA_PRINTABLE_CHECK_EN` (see Configuration).

## Operation
- **Memories:** all memories are synchronous with 1-cycle read latency. An address driven in cycle n gives valid rddata in cycle n+1. A write is committed at the edge ending the cycle in which wren=1.
- **Message format:**
  - ct[0] = length L (0..255); ct[1..L] = ciphertext bytes.
  - pt[0] = L; pt[k] = ct[k] ^ pad_k.
- **Algorithm:** start with i=0, j=0. For k = 1..L:
  - i = i+1
  - j = j+S[i]
  - swap S[i] and S[j]
  - pad_k = S[S[i]+S[j]]
  - All sums are 8-bit and wrap mod 256.
- **State machine:**
  - `IDLE` (rdy=1): if en=1 → `RD_LEN`.
  - `RD_LEN`: ct_addr=0.
  - `WAIT_LEN`: latch len=ct_rddata.
  - `WR_LEN`: pt_addr=0, pt_wrdata=len, pt_wren=1. Set k=1, i=1, j=0. If len=0 → `IDLE`, else → `RD_SI`.
  - `RD_SI`: s_addr=i.
  - `WAIT_SI`: latch si=s_rddata; j ← j+si.
  - `RD_SJ`: s_addr=j.
  - `WAIT_SJ`: latch sj=s_rddata.
  - `WR_SI`: s_addr=i, s_wrdata=sj, s_wren=1.
  - `WR_SJ`: s_addr=j, s_wrdata=si, s_wren=1; ct_addr=k.
  - `RD_PAD`: s_addr=si+sj.
  - `WAIT_PAD`: latch pad=s_rddata and ct=ct_rddata.
  - `WR_PT`: pt_addr=k, pt_wrdata=pad^ct, pt_wren=1. If k=len → `IDLE`; else k←k+1, i←i+1, → `RD_SI`.
- **i=j case:** si=sj, so both swap writes store the same value and S is unchanged. No special handling.
- **Counter width:** k is 8-bit. L=255 ends on the compare k=len, so k never wraps.
- **Write enables:** s_wren and pt_wren are never both asserted, and each is asserted only in the states listed above. Addresses and data are don't-care when the enable is 0 but must be driven (no X).
- **en while busy:** ignored. If en is held high, a new run starts on the first cycle rdy=1.

## Timing
- **Reset values:** rdy=1, s_wren=0, pt_wren=0, s_addr=ct_addr=pt_addr=0, s_wrdata=pt_wrdata=0, state=`IDLE`, i=j=k=len=0.
- **Busy duration:** en is accepted at edge E0. rdy falls after E0 and stays 0 for exactly 3+9·L cycles. rdy rises after the edge that completes the final write (`WR_LEN` if L=0, otherwise the last `WR_PT`).
- **Throughput:** 9 cycles per byte.
- **First pt write:** pt[0] is written 2 cycles after RD_LEN.
- **Reset mid-operation:** asynchronous return to `IDLE` with reset values. Any write already committed stays in memory; no rollback.

## Configuration
- **Macro:** `PRGA_PRINTABLE_CHECK_EN`.
- **Defined:**
  - Port `pt_valid` exists; reset value 0.
  - Set to 1 on en acceptance.
  - Cleared in any `WR_PT` whose pt_wrdata is outside 0x20..0x7E. pt[0] is never checked.
  - Holds its value while rdy=1. For L=0 it reads 1.
- **Undefined:** port and logic are absent. All other behaviour and timing are identical.

## Test plan
- **Reset:** assert rst_n=0 mid-clock → all outputs take reset values immediately, without a clock edge.
- **Three-byte decrypt:** S[x]=x, ct={03,00,00,00}, pulse en → pt={03,02,05,07}. S ends with S[1]=01, S[2]=03, S[3]=05, S[5]=02 and all other entries untouched. rdy stays 0 for 30 cycles.
- **Zero length:** ct[0]=00 → only pt[0]=00 is written, no s_wren, rdy back after 3 cycles.
- **Handshake:** en pulsed during a run → ignored, with exactly one pt[0] write per run. en held high → back-to-back runs with one rdy=1 cycle between them.
- **Reset mid-run:** rst_n low during the 2nd byte's `WR_SI` → rdy=1 and no further writes. A fresh en then completes a full 255-byte run in 3+9·255 = 2298 cycles with correct XOR results (checked against a reference model).
- **Printable check (macro defined):**
  - Keystream forced so that pt={02,41,42} → pt_valid=1.
  - Same run with pt[2]=0x0A → pt_valid=0.
  - Macro undefined → build has no pt_valid port.

Source files
------------

// File: rtl/prga_if.sv
// prga_if: ARC4 PRGA request handshake plus S/ct/pt memory ports; pt_valid exists only with PRGA_PRINTABLE_CHECK_EN
interface prga_if;
  logic en;
  logic rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic pt_wren;
`ifdef PRGA_PRINTABLE_CHECK_EN
  logic pt_valid;
`endif
  modport master (
`ifdef PRGA_PRINTABLE_CHECK_EN
    output pt_valid,
`endif
    input en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
  modport slave (
`ifdef PRGA_PRINTABLE_CHECK_EN
    input pt_valid,
`endif
    output en, s_rddata, ct_rddata,
    input rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// prga: ARC4 keystream generation and ct->pt XOR; PRGA_PRINTABLE_CHECK_EN adds the pt_valid all-printable flag
module prga (
  input logic clk,
  input logic rst_n,
  prga_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, RD_LEN, WAIT_LEN, WR_LEN, RD_SI, WAIT_SI, RD_SJ,
    WAIT_SJ, WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_PT
  } state_t;
  state_t state;
  logic [7:0] i, j, k, len, si, sj;
  // Sequencer; every memory-port output is loaded on the edge entering the state that owns it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.rdy <= 1'b1;
      bus.s_addr <= 8'd0;
      bus.s_wrdata <= 8'd0;
      bus.s_wren <= 1'b0;
      bus.ct_addr <= 8'd0;
      bus.pt_addr <= 8'd0;
      bus.pt_wrdata <= 8'd0;
      bus.pt_wren <= 1'b0;
`ifdef PRGA_PRINTABLE_CHECK_EN
      bus.pt_valid <= 1'b0;
`endif
      i <= 8'd0;
      j <= 8'd0;
      k <= 8'd0;
      len <= 8'd0;
      si <= 8'd0;
      sj <= 8'd0;
    end else
      case (state)
        IDLE:
          if (bus.en) begin
            state <= RD_LEN;
            bus.rdy <= 1'b0;
            bus.ct_addr <= 8'd0;
`ifdef PRGA_PRINTABLE_CHECK_EN
            bus.pt_valid <= 1'b1;
`endif
          end
        RD_LEN: state <= WAIT_LEN;
        WAIT_LEN: begin
          len <= bus.ct_rddata;
          bus.pt_addr <= 8'd0;
          bus.pt_wrdata <= bus.ct_rddata;
          bus.pt_wren <= 1'b1;
          state <= WR_LEN;
        end
        WR_LEN: begin
          bus.pt_wren <= 1'b0;
          k <= 8'd1;
          i <= 8'd1;
          j <= 8'd0;
          bus.s_addr <= 8'd1;
          bus.rdy <= len == 8'd0;
          state <= len == 8'd0 ? IDLE : RD_SI;
        end
        RD_SI: state <= WAIT_SI;
        WAIT_SI: begin
          si <= bus.s_rddata;
          j <= j + bus.s_rddata;
          bus.s_addr <= j + bus.s_rddata;
          state <= RD_SJ;
        end
        RD_SJ: state <= WAIT_SJ;
        WAIT_SJ: begin
          sj <= bus.s_rddata;
          bus.s_addr <= i;
          bus.s_wrdata <= bus.s_rddata;
          bus.s_wren <= 1'b1;
          state <= WR_SI;
        end
        WR_SI: begin
          bus.s_addr <= j;
          bus.s_wrdata <= si;
          bus.ct_addr <= k;
          state <= WR_SJ;
        end
        WR_SJ: begin
          bus.s_wren <= 1'b0;
          bus.s_addr <= si + sj;
          state <= RD_PAD;
        end
        RD_PAD: state <= WAIT_PAD;
        WAIT_PAD: begin
          bus.pt_addr <= k;
          bus.pt_wrdata <= bus.s_rddata ^ bus.ct_rddata;
          bus.pt_wren <= 1'b1;
          state <= WR_PT;
        end
        WR_PT: begin
          bus.pt_wren <= 1'b0;
`ifdef PRGA_PRINTABLE_CHECK_EN
          if (bus.pt_wrdata < 8'h20 || bus.pt_wrdata > 8'h7e) bus.pt_valid <= 1'b0;
`endif
          if (k == len) begin
            bus.rdy <= 1'b1;
            state <= IDLE;
          end else begin
            k <= k + 8'd1;
            i <= i + 8'd1;
            bus.s_addr <= i + 8'd1;
            state <= RD_SI;
          end
        end
        default: state <= IDLE;
      endcase
endmodule
